// File: rtl/rle_encode_fifo.sv
// Run-length encoder with an internal first-word-fall-through pair FIFO.
// Incoming bytes are collapsed into (symbol, count) pairs with count 1..MAX_RUN.
// Closed pairs are queued, and the reader pops one pair per rd_en.
module rle_encode_fifo #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4,
   parameter int ADR_W  = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_dout,
   output logic [CNT_W-1:0]  data_cout,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 1 << ADR_W;
   localparam int PAIR_W = DATA_W + CNT_W;
   localparam logic [CNT_W-1:0] MAX_RUN = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [ADR_W:0] OCC_FULL = DEPTH[ADR_W:0];

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   cur_q, cur_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                push;
   logic [DATA_W-1:0]   push_data;
   logic [CNT_W-1:0]    push_cnt;
   logic                accept;

   logic [PAIR_W-1:0]   mem [DEPTH];
   logic [ADR_W-1:0]    wr_ptr, rd_ptr;
   logic [ADR_W:0]      occ;
   logic                wr, pop;
   logic [PAIR_W-1:0]   head;

   // Status flags come from occupancy. Input is stalled while the FIFO is full
   // or while a run that was opened by the last byte is still waiting to be written.
   assign empty    = (occ == '0);
   assign full     = (occ == OCC_FULL);
   assign in_ready = !full && (state_q != FLUSH);
   assign accept   = in_valid && in_ready;

   // Encoder next-state logic. Every accept implies !full, so a push from
   // IDLE or RUN always finds space in the FIFO.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_data = cur_q;
      push_cnt  = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cur_d = in_data;
               if (in_last) begin
                  // A single-byte frame closes immediately.
                  push      = 1'b1;
                  push_data = in_data;
                  push_cnt  = ONE;
                  cnt_d     = '0;
               end else begin
                  cnt_d   = ONE;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (in_data == cur_q && cnt_q != MAX_RUN) begin
                  cnt_d = cnt_q + 1'b1;
                  if (in_last) begin
                     push     = 1'b1;
                     push_cnt = cnt_q + 1'b1;
                     cnt_d    = '0;
                     state_d  = IDLE;
                  end
               end else begin
                  // The run is broken by a new symbol or a saturated count.
                  // The new byte opens a fresh run of one.
                  push  = 1'b1;
                  cur_d = in_data;
                  cnt_d = ONE;
                  if (in_last) state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            // The one-byte run opened by the last byte is written once space exists.
            if (!full) begin
               push      = 1'b1;
               push_data = cur_q;
               push_cnt  = ONE;
               cnt_d     = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Encoder state register. Reset discards any open run.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wr  = push && !full;
   assign pop = rd_en && !empty;

   // Pair storage. Unread entries are invalidated by the pointer reset, so the
   // array itself needs no reset.
   always_ff @(posedge CLK) begin
      if (wr) mem[wr_ptr] <= {push_data, push_cnt};
   end

   // Pointers and occupancy. A push and a pop in the same cycle leave the
   // occupancy unchanged.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // The head pair falls through combinationally and is blanked to zero when the FIFO is empty.
   assign head      = mem[rd_ptr];
   assign data_dout = empty ? '0 : head[PAIR_W-1:CNT_W];
   assign data_cout = empty ? '0 : head[CNT_W-1:0];

endmodule

// File: tb/tb_rle_encode_fifo.sv
// Bench for rle_encode_fifo. It runs directed scenarios and a random stream
// that is checked against a run-grouping reference and a decoder replay.
module tb_rle_encode_fifo;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       rd_en = 1'b0;
   logic [7:0] data_dout;
   logic [3:0] data_cout;
   logic       full, empty;

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] exp_q[$];
   logic [11:0] got_q[$];
   bit          mon_en = 0;
   bit          saw_full = 0;

   rle_encode_fifo #(.DATA_W(8), .CNT_W(4), .ADR_W(3)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .rd_en(rd_en),
      .data_dout(data_dout), .data_cout(data_cout), .full(full), .empty(empty)
   );

   always #5 CLK = ~CLK;

   // Pairs popped during streaming, sampled half a cycle before the pop edge
   always @(negedge CLK) begin
      if (mon_en) begin
         if (rd_en && !empty) got_q.push_back({data_dout, data_cout});
         if (full) saw_full = 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder for one frame: group equal neighbours, then split each group into chunks of at most 15.
   task automatic rle(input logic [7:0] seg[$]);
      int i = 0;
      while (i < seg.size()) begin
         int j = i;
         int len;
         while (j < seg.size() && seg[j] == seg[i]) j++;
         len = j - i;
         while (len > 15) begin
            exp_q.push_back({seg[i], 4'd15});
            len -= 15;
         end
         exp_q.push_back({seg[i], 4'(len)});
         i = j;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; rd_en = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic lst);
      bit ok = 0;
      in_valid = 1'b1; in_data = d; in_last = lst;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge CLK);
         if (in_ready) begin
            @(posedge CLK);
            #1 ok = 1;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("send_accept", 32'(ok), 32'd1);
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(posedge CLK);
      #1 rd_en = 1'b0;
   endtask

   // Pop every expected pair, checking each head before it is popped.
   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         logic [11:0] e = exp_q.pop_front();
         chk({tag, "_data"}, 32'(data_dout), 32'(e[11:4]));
         chk({tag, "_cnt"},  32'(data_cout), 32'(e[3:0]));
         pop();
      end
      chk({tag, "_empty"}, 32'(empty), 32'd1);
   endtask

   logic [7:0] seg[$];
   logic [7:0] bytes[$];
   bit         lasts[$];
   logic [7:0] dec[$];

   initial begin
      // Reset state
      do_reset();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_dout", 32'(data_dout), 32'd0);
      chk("rst_cout", 32'(data_cout), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      // T1: A5 x3, then 3C closing the frame
      exp_q.delete();
      send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h3C, 1);
      chk("t1_flush_ready", 32'(in_ready), 32'd0);
      @(posedge CLK); #1;
      chk("t1_idle_ready", 32'(in_ready), 32'd1);
      exp_q.push_back({8'hA5, 4'd3});
      exp_q.push_back({8'h3C, 4'd1});
      drain("t1");

      // T2: 17 x 11 splits at the maximum run length
      for (int i = 0; i < 17; i++) send(8'h11, i == 16);
      @(posedge CLK); #1;
      chk("t2_head_cnt", 32'(data_cout), 32'd15);
      seg.delete();
      for (int i = 0; i < 17; i++) seg.push_back(8'h11);
      rle(seg);
      chk("t2_npairs", 32'(exp_q.size()), 32'd2);
      drain("t2");

      // T3: fill the FIFO, hold a byte under backpressure, then release it
      do_reset();
      for (int i = 1; i <= 9; i++) send(8'(i), 0);
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; in_data = 8'h0A; in_last = 1'b0;
      repeat (3) @(posedge CLK); #1;
      chk("t3_hold_ready", 32'(in_ready), 32'd0);
      chk("t3_head", 32'({data_dout, data_cout}), 32'h011);
      pop();
      chk("t3_pop_full", 32'(full), 32'd0);
      chk("t3_pop_ready", 32'(in_ready), 32'd1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      chk("t3_refull", 32'(full), 32'd1);
      exp_q.delete();
      for (int i = 2; i <= 9; i++) exp_q.push_back({8'(i), 4'd1});
      drain("t3");

      // T4: a frame end that finds the FIFO full stalls until a pop
      do_reset();
      for (int i = 1; i <= 7; i++) send(8'(i), 0);
      for (int i = 0; i < 4; i++) send(8'h22, 0);
      send(8'h33, 1);
      chk("t4_full", 32'(full), 32'd1);
      repeat (3) @(posedge CLK); #1;
      chk("t4_wait_ready", 32'(in_ready), 32'd0);
      chk("t4_head", 32'({data_dout, data_cout}), 32'h011);
      pop();
      chk("t4_flush_ready", 32'(in_ready), 32'd0);
      @(posedge CLK); #1;
      chk("t4_flush_full", 32'(full), 32'd1);
      exp_q.delete();
      for (int i = 2; i <= 7; i++) exp_q.push_back({8'(i), 4'd1});
      exp_q.push_back({8'h22, 4'd4});
      exp_q.push_back({8'h33, 4'd1});
      drain("t4");
      chk("t4_end_ready", 32'(in_ready), 32'd1);

      // T5: reset in the middle of a run discards everything
      do_reset();
      send(8'h10, 0); send(8'h20, 0);
      for (int i = 0; i < 5; i++) send(8'h7E, 0);
      chk("t5_pre_empty", 32'(empty), 32'd0);
      RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      chk("t5_empty", 32'(empty), 32'd1);
      chk("t5_full", 32'(full), 32'd0);
      chk("t5_outs", 32'({data_dout, data_cout}), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd1);
      send(8'h7E, 0); send(8'h7E, 1);
      @(posedge CLK); #1;
      exp_q.delete();
      exp_q.push_back({8'h7E, 4'd2});
      drain("t5");

      // T6: random back-to-back stream with continuous reads, replayed through a decoder
      do_reset();
      while (bytes.size() < 1000) begin
         logic [7:0] s = 8'h40 + 8'($urandom_range(0, 3));
         int len = $urandom_range(1, 40);
         for (int i = 0; i < len && bytes.size() < 1000; i++) bytes.push_back(s);
      end
      for (int i = 0; i < 1000; i++) lasts.push_back(i == 999 || $urandom_range(0, 29) == 0);
      exp_q.delete(); seg.delete();
      for (int i = 0; i < 1000; i++) begin
         seg.push_back(bytes[i]);
         if (lasts[i]) begin rle(seg); seg.delete(); end
      end
      got_q.delete();
      mon_en = 1; rd_en = 1'b1;
      for (int i = 0; i < 1000; i++) send(bytes[i], lasts[i]);
      repeat (6) @(posedge CLK); #1;
      mon_en = 0; rd_en = 1'b0;
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_never_full", 32'(saw_full), 32'd0);
      chk("t6_npairs", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("t6_pair%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      dec.delete();
      foreach (got_q[i])
         for (int k = 0; k < int'(got_q[i][3:0]); k++) dec.push_back(got_q[i][11:4]);
      chk("t6_dec_len", 32'(dec.size()), 32'd1000);
      begin
         int bad = 0;
         for (int i = 0; i < dec.size() && i < 1000; i++) if (dec[i] !== bytes[i]) bad++;
         chk("t6_dec_bytes", 32'(bad), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
